// File: rtl/phase_stim_pkg.sv
// phase_stim_pkg: shared state encoding and default widths for the phase stimulus generator
package phase_stim_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int BURST_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/pulse_channel.sv
// pulse_channel: armable phase counter producing a registered pulse while phase < width
module pulse_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  output logic             pulse,
  output logic             active,
  output logic             wrap
);
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] nxt;
  assign wrap = active && phase == period - 1'b1;
  assign nxt = wrap ? '0 : phase + 1'b1;
  // arming starts phase 0 on the very next cycle; clear wins so the channel can be silenced mid-period
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      active <= 1'b0;
      phase <= '0;
      pulse <= 1'b0;
    end else if (arm) begin
      active <= 1'b1;
      phase <= '0;
      pulse <= width != '0;
    end else if (active) begin
      phase <= nxt;
      pulse <= nxt < width;
    end
  end
endmodule

// File: rtl/phase_stimulus_gen.sv
// phase_stimulus_gen: two pulse trains with an exact programmable rising-edge offset
module phase_stimulus_gen import phase_stim_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   width,
  input  logic [CNT_W-1:0]   delay,
  input  logic               lead_2,
  input  logic [BURST_W-1:0] burst,
  output logic               signal_1,
  output logic               signal_2,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_count
);
  state_t state, state_n;
  logic [CNT_W-1:0] p_q, w_q, d_q, ecnt, p_c, w_c, d_c, p_e, w_e;
  logic [BURST_W-1:0] b_q, bc;
  logic l2_q, accept, last, fin;
  logic lead_arm, lag_arm, lead_clr, lag_clr;
  logic lead_pulse, lag_pulse, lead_act, lag_act, lead_wrap, lag_wrap;
  assign p_c = period < CNT_W'(2) ? CNT_W'(2) : period;
  assign w_c = width >= p_c ? p_c - 1'b1 : width;
  assign d_c = delay >= p_c ? p_c - 1'b1 : delay;
  assign accept = state == IDLE && start;
  assign p_e = accept ? p_c : p_q;
  assign w_e = accept ? w_c : w_q;
  assign last = state == RUN && lead_wrap && b_q != '0 && bc == b_q - 1'b1;
  assign busy = state != IDLE;
  assign signal_1 = l2_q ? lag_pulse : lead_pulse;
  assign signal_2 = l2_q ? lead_pulse : lag_pulse;
  pulse_channel #(.CNT_W(CNT_W)) lead_ch (
    .clk(clock), .rst(reset), .arm(lead_arm), .clear(lead_clr),
    .period(p_e), .width(w_e), .pulse(lead_pulse), .active(lead_act), .wrap(lead_wrap)
  );
  pulse_channel #(.CNT_W(CNT_W)) lag_ch (
    .clk(clock), .rst(reset), .arm(lag_arm), .clear(lag_clr),
    .period(p_e), .width(w_e), .pulse(lag_pulse), .active(lag_act), .wrap(lag_wrap)
  );
  // sequencing: lag arms after delay run cycles, drain lets the lag channel finish its last period
  always_comb begin
    state_n = state;
    lead_arm = 1'b0;
    lag_arm = 1'b0;
    lead_clr = 1'b0;
    lag_clr = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        lead_arm = 1'b1;
        lag_arm = d_c == '0;
      end
      RUN: if (stop) fin = 1'b1;
      else begin
        lag_arm = lead_act && !lag_act && ecnt == d_q - 1'b1;
        if (last) begin
          state_n = DRAIN;
          lead_clr = 1'b1;
          fin = d_q == '0;
        end
      end
      DRAIN: fin = stop || lag_wrap;
      default: state_n = IDLE;
    endcase
    if (fin) begin
      state_n = IDLE;
      lead_clr = 1'b1;
      lag_clr = 1'b1;
    end
  end
  // config latch at accept, run-time counters and the saturating leading-edge count
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      p_q <= '0;
      w_q <= '0;
      d_q <= '0;
      l2_q <= 1'b0;
      b_q <= '0;
      bc <= '0;
      ecnt <= '0;
      pulse_count <= '0;
    end else begin
      state <= state_n;
      done <= fin;
      if (accept) begin
        p_q <= p_c;
        w_q <= w_c;
        d_q <= d_c;
        l2_q <= lead_2;
        b_q <= burst;
        bc <= '0;
        ecnt <= '0;
        pulse_count <= BURST_W'(w_c != '0);
      end else if (state == RUN) begin
        if (!lag_act) ecnt <= ecnt + 1'b1;
        if (lead_wrap) bc <= bc + 1'b1;
        if (lead_wrap && !last && !stop && w_q != '0 && pulse_count != '1)
          pulse_count <= pulse_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phase_stimulus_gen.sv
// tb_phase_stimulus_gen: directed waveform checks of phase_stimulus_gen
module tb_phase_stimulus_gen;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, lead_2 = 1'b0;
  logic [31:0] period = '0, width = '0, delay = '0;
  logic [15:0] burst = '0;
  logic signal_1, signal_2, busy, done;
  logic [15:0] pulse_count;
  logic [63:0] c1, c2, cb, cd;
  logic [15:0] cpc [64];
  int tests = 0, fails = 0;
  phase_stimulus_gen dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .period(period), .width(width), .delay(delay), .lead_2(lead_2), .burst(burst),
    .signal_1(signal_1), .signal_2(signal_2), .busy(busy), .done(done), .pulse_count(pulse_count)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++) v[i] = i >= lo && i <= hi;
    return v;
  endfunction
  function automatic logic [63:0] wave(input int p, input int w, input int off, input int b, input int last);
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++)
      v[i] = i >= 1 + off && i <= last && (b == 0 || i <= b * p + off) && ((i - 1 - off) % p) < w;
    return v;
  endfunction
  task automatic run(input int p, input int w, input int d, input logic l2, input int b,
                     input int stop_at, input int rst_at, input int restart_at);
    period = p;
    width = w;
    delay = d;
    lead_2 = l2;
    burst = 16'(b);
    start = 1'b1;
    for (int i = 0; i < 64; i++) begin
      stop = i == stop_at;
      reset = i == rst_at;
      if (i > 0) start = i == restart_at;
      if (i == restart_at) period = 7;
      c1[i] = signal_1;
      c2[i] = signal_2;
      cb[i] = busy;
      cd[i] = done;
      cpc[i] = pulse_count;
      tick;
    end
    start = 1'b0;
    stop = 1'b0;
    reset = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    tick;
    check("rst_s1", signal_1, 0);
    check("rst_s2", signal_2, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pulse_count, 0);
    run(10, 3, 4, 1'b0, 3, -1, -1, -1);
    check("base_s1", c1, wave(10, 3, 0, 3, 63));
    check("base_s2", c2, wave(10, 3, 4, 3, 63));
    check("base_s1_rise", c1 & ~(c1 << 1), 64'h0020_0802);
    check("base_s2_rise", c2 & ~(c2 << 1), 64'h0200_8020);
    check("base_busy", cb, span(1, 34));
    check("base_done", cd, 64'h8_0000_0000);
    check("base_pc", cpc[36], 3);
    run(10, 3, 4, 1'b1, 3, -1, -1, -1);
    check("swap_s2", c2, wave(10, 3, 0, 3, 63));
    check("swap_s1", c1, wave(10, 3, 4, 3, 63));
    check("swap_done", cd, span(35, 35));
    check("swap_pc", cpc[36], 3);
    run(1, 7, 9, 1'b0, 3, -1, -1, -1);
    check("clamp_s1", c1, 64'h2A);
    check("clamp_s2", c2, 64'h54);
    check("clamp_done", cd, 64'h100);
    run(10, 3, 4, 1'b0, 0, 17, -1, -1);
    check("abort_s1", c1, 64'h380E);
    check("abort_s2", c2, 64'h3_80E0);
    check("abort_busy", cb, span(1, 17));
    check("abort_done", cd, 64'h4_0000);
    check("abort_pc", cpc[17], 2);
    run(10, 3, 4, 1'b0, 3, -1, 8, -1);
    check("rst_mid_s1", c1, 64'hE);
    check("rst_mid_s2", c2, 64'hE0);
    check("rst_mid_busy", cb, 64'h1FE);
    check("rst_mid_done", cd, 0);
    check("rst_mid_pc", cpc[9], 0);
    run(10, 3, 4, 1'b0, 3, -1, -1, 6);
    check("restart_s1", c1, wave(10, 3, 0, 3, 63));
    check("restart_s2", c2, wave(10, 3, 4, 3, 63));
    check("restart_done", cd, span(35, 35));
    run(10, 3, 4, 1'b0, 3, 0, -1, -1);
    check("startstop_s1", c1, wave(10, 3, 0, 3, 63));
    check("startstop_done", cd, span(35, 35));
    run(10, 3, 4, 1'b0, 3, 34, -1, -1);
    check("laststop_s2", c2, wave(10, 3, 4, 3, 63));
    check("laststop_done", cd, span(35, 35));
    run(5, 2, 0, 1'b0, 2, -1, -1, -1);
    check("d0_s1", c1, 64'hC6);
    check("d0_s2", c2, 64'hC6);
    check("d0_busy", cb, 64'h7FE);
    check("d0_done", cd, 64'h800);
    run(6, 0, 2, 1'b0, 2, -1, -1, -1);
    check("w0_s1", c1, 0);
    check("w0_s2", c2, 0);
    check("w0_done", cd, 64'h8000);
    check("w0_pc", cpc[20], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/phase_stimulus_gen.md
# phase_stimulus_gen

- Generates two programmable pulse trains, `signal_1` and `signal_2`, with an exact, cycle-accurate rising-edge offset between them.
- Serves as the transmit-side counterpart to `Phase_Detection`. It drives the mic-signal inputs in loopback/self-test, or drives the emitter for known-delay calibration.
- Looped into `Phase_Detection`, it must produce `time_2 - time_1 == delay` (or `time_1 - time_2` when `lead_2=1`).

## Interface

Parameters:
- `CNT_W`, 32: width of `period`, `width`, `delay` and their internal counters.
- `BURST_W`, 16: width of `burst` and `pulse_count`.

Ports:
- `clock`, in, 1: reference clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request; accepted only in IDLE.
- `stop`, in, 1: abort request; honoured in RUN and DRAIN.
- `period`, in, CNT_W: cycles per pulse period.
- `width`, in, CNT_W: high time in cycles.
- `delay`, in, CNT_W: lag of the trailing channel, in cycles.
- `lead_2`, in, 1: 0 means `signal_1` leads; 1 means `signal_2` leads.
- `burst`, in, BURST_W: number of periods; 0 means continuous until `stop`.
- `signal_1`, out, 1: registered pulse output.
- `signal_2`, out, 1: registered pulse output.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse on completion or abort.
- `pulse_count`, out, BURST_W: leading-channel rising edges emitted since the last accepted `start`.

## Operation

- Reset values: all outputs 0 and state IDLE. Reset overrides everything, including mid-burst.
- `start` accepted (IDLE only): latch `period`, `width`, `delay`, `lead_2`, `burst`; clear `pulse_count`; enter RUN. `start` in any other state is ignored.
- Config is clamped at latch time. Apply the clamps in this order:
  - `period` < 2 → 2.
  - `width` ≥ `period` → `period`-1.
  - `delay` ≥ `period` → `period`-1.
- `width` = 0 is legal: both outputs stay low and the counters and timing run normally.
- Config inputs are ignored outside the accept cycle.
- Leading channel:
  - Phase counter `lc` runs 0..period-1 and wraps.
  - Output is high while `lc < width`.
  - `pulse_count` increments on each `lc == 0` with `width` > 0, saturating at all-ones.
- Trailing channel:
  - Its own phase counter arms once `delay` cycles have elapsed since RUN entry.
  - It then mirrors the leading channel. It is never high before arming, so there is no spurious first edge.
- States:
  - IDLE: outputs low.
  - RUN → DRAIN after `burst` complete leading periods (never when `burst`=0). Leading output low in DRAIN.
  - DRAIN: trailing channel finishes its final period (`delay` cycles), then → IDLE with `done`=1. With `delay`=0, DRAIN is skipped and the block goes RUN → IDLE.
  - `stop` in RUN or DRAIN: both outputs low next cycle, `done`=1, → IDLE.
- Simultaneous events:
  - `start` and `stop` in IDLE: start is accepted.
  - `stop` on the final DRAIN cycle: a single `done`.

## Timing

- `start` sampled at edge T: leading output is high during cycles T+1 .. T+width; the k-th leading rise is at T+1+k·period.
- Trailing rises occur at T+1+delay+k·period. The edge separation is exactly `delay` cycles.
- `busy` is high from T+1 through T+burst·period+delay.
- `done` is high for one cycle at T+1+burst·period+delay; `busy` is low in that same cycle.
- After `stop` sampled at S: outputs are low, `done`=1 and `busy`=0 at S+1.
- Next `start` is accepted in the `done` cycle or any later cycle.

## Structure

- Package `phase_stim_pkg`: state enum (IDLE, RUN, DRAIN) and default `CNT_W`/`BURST_W` constants.
- Sub-module `pulse_channel`: arm input, phase counter, width compare and registered output. It is instantiated twice.
- Top level holds the FSM, clamp logic, burst counter, lead/lag swap mux and `pulse_count`.

## Test plan

- Baseline, `period`=10, `width`=3, `delay`=4, `lead_2`=0, `burst`=3, `start` at T:
  - `signal_1` rises at T+1, T+11, T+21.
  - `signal_2` rises at T+5, T+15, T+25.
  - `done` at T+35; `pulse_count`=3.
- Lead swap, same config with `lead_2`=1: `signal_2` rises at T+1, `signal_1` at T+5. Loopback into `Phase_Detection` gives `time_1 - time_2` = 4.
- Clamps, `period`=1, `width`=7, `delay`=9: effective period 2, width 1, delay 1. Alternating pulses with a one-cycle offset.
- Abort, `burst`=0, `stop` at T+17: both outputs low and `done`=1 at T+18; `busy` low at T+18.
- Reset and repeated start:
  - `reset` at T+8 of a burst: all outputs are 0 at T+9.
  - `start` pulsed while `busy`: ignored, and the original timing is unchanged.
- Zero-delay and zero-width:
  - `delay`=0: coincident edges, no DRAIN, `done` at T+1+burst·period.
  - `width`=0: no pulses, `pulse_count`=0, `done` still on schedule.
